// File: rtl/lp_pkg.sv
// Shared constants and types for the LP solver input feeder.
package lp_pkg;

  localparam int LP_A_W         = 6;
  localparam int LP_B_W         = 12;
  localparam int LP_FRAME_WORDS = 7;

  typedef struct packed {
    logic signed [LP_A_W-1:0] a1;
    logic signed [LP_A_W-1:0] a2;
    logic signed [LP_B_W-1:0] b;
  } lp_word_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } lp_feed_state_e;

  // One-hot tag of which box-bound row (1,0),(-1,0),(0,1),(0,-1) a constraint is.
  function automatic logic [3:0] bound_mask(input logic signed [LP_A_W-1:0] a1,
                                            input logic signed [LP_A_W-1:0] a2);
    logic [3:0] m;
    m[0] = (a1 == 6'sd1)  && (a2 == 6'sd0);
    m[1] = (a1 == -6'sd1) && (a2 == 6'sd0);
    m[2] = (a1 == 6'sd0)  && (a2 == 6'sd1);
    m[3] = (a1 == 6'sd0)  && (a2 == -6'sd1);
    return m;
  endfunction

endpackage

// File: rtl/lp_feed_slot.sv
// One 7-word frame buffer: write index, full flag, clear input and indexed read port.
// With LP_FEED_CHECK_EN defined, a completed frame lacking any bound row is dropped.
module lp_feed_slot
  import lp_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     wr,
  input  lp_word_t wr_data,
  input  logic     clr,
  input  logic [2:0] rd_idx,
  output lp_word_t rd_data,
  output logic     full,
`ifdef LP_FEED_CHECK_EN
  output logic     drop,
`endif
  output logic     done
);

  lp_word_t   mem [LP_FRAME_WORDS];
  logic [2:0] wr_idx_reg;
  logic       full_reg;
  logic       last;
  logic       keep;

  assign last = wr && (wr_idx_reg == 3'(LP_FRAME_WORDS - 1));

`ifdef LP_FEED_CHECK_EN
  logic [3:0] seen_reg;
  logic [3:0] seen_all;

  // The last word's bound tag is folded in combinationally so the verdict lands on the completing edge.
  assign seen_all = seen_reg | bound_mask(wr_data.a1, wr_data.a2);
  assign keep     = (seen_all == 4'hF);
  assign drop     = last && !keep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_reg <= '0;
    end else if (wr) begin
      if (wr_idx_reg == 3'd0) begin
        seen_reg <= '0;
      end else begin
        seen_reg <= seen_all;
      end
    end
  end
`else
  assign keep = 1'b1;
`endif

  assign done = last && keep;
  assign full = full_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_reg <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (clr) begin
        full_reg <= 1'b0;
      end
      if (wr) begin
        wr_idx_reg <= last ? 3'd0 : wr_idx_reg + 3'd1;
        if (done) begin
          full_reg <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_idx_reg] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/lp_feeder.sv
// Ping-pong frame buffer feeding 7-word bursts to the LP solver, one burst per solver result.
// Optional frame check enabled by defining LP_FEED_CHECK_EN.
module lp_feeder
  import lp_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [LP_A_W-1:0] s_a1,
  input  logic signed [LP_A_W-1:0] s_a2,
  input  logic signed [LP_B_W-1:0] s_b,
  output logic                     lp_in_valid,
  output logic signed [LP_A_W-1:0] lp_in_a1,
  output logic signed [LP_A_W-1:0] lp_in_a2,
  output logic signed [LP_B_W-1:0] lp_in_b,
  input  logic                     lp_out_valid,
  output logic                     busy,
  output logic [7:0]               frame_cnt,
  output logic                     drop_pulse
);

  lp_feed_state_e state_reg, state_next;
  logic       wr_sel_reg;
  logic       rd_sel_reg;
  logic [2:0] send_idx_reg;
  logic [3:0] gap_reg;
  logic [7:0] frame_cnt_reg;
  logic       send_last;
  logic       accept;

  lp_word_t   s_word;
  lp_word_t   rd_word [2];
  lp_word_t   burst_word;
  logic [1:0] full;
  logic [1:0] done;
  logic [1:0] wr;
  logic [1:0] clr;

  assign s_word  = '{a1: s_a1, a2: s_a2, b: s_b};
  assign s_ready = !full[wr_sel_reg];
  assign accept  = s_valid && s_ready;

`ifdef LP_FEED_CHECK_EN
  logic [1:0] drop;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign wr[gi]  = accept && (wr_sel_reg == 1'(gi));
    assign clr[gi] = send_last && (rd_sel_reg == 1'(gi));

    lp_feed_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr[gi]),
      .wr_data (s_word),
      .clr     (clr[gi]),
      .rd_idx  (send_idx_reg),
      .rd_data (rd_word[gi]),
      .full    (full[gi]),
`ifdef LP_FEED_CHECK_EN
      .drop    (drop[gi]),
`endif
      .done    (done[gi])
    );
  end

  always_comb begin
    state_next = state_reg;
    send_last  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gap_reg == 4'd0 && full[rd_sel_reg]) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (send_idx_reg == 3'(LP_FRAME_WORDS - 1)) begin
          send_last  = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (lp_out_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      wr_sel_reg    <= 1'b0;
      rd_sel_reg    <= 1'b0;
      send_idx_reg  <= '0;
      gap_reg       <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Only a kept frame advances the write side; a dropped one reuses its slot.
      if (|done) begin
        wr_sel_reg <= !wr_sel_reg;
      end
      if (state_reg == SEND && !send_last) begin
        send_idx_reg <= send_idx_reg + 3'd1;
      end else begin
        send_idx_reg <= '0;
      end
      if (send_last) begin
        rd_sel_reg    <= !rd_sel_reg;
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
      if (state_reg == WAIT && lp_out_valid) begin
        gap_reg <= 4'(GAP_CYCLES);
      end else if (state_reg == IDLE && gap_reg != 4'd0) begin
        gap_reg <= gap_reg - 4'd1;
      end
    end
  end

`ifdef LP_FEED_CHECK_EN
  logic drop_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_reg <= 1'b0;
    end else begin
      drop_reg <= |drop;
    end
  end

  assign drop_pulse = drop_reg;
`else
  assign drop_pulse = 1'b0;
`endif

  assign lp_in_valid = (state_reg == SEND);
  assign busy        = (state_reg == SEND) || (state_reg == WAIT);
  assign frame_cnt   = frame_cnt_reg;
  assign burst_word  = lp_in_valid ? rd_word[rd_sel_reg] : '0;
  assign lp_in_a1    = burst_word.a1;
  assign lp_in_a2    = burst_word.a2;
  assign lp_in_b     = burst_word.b;

endmodule

// File: tb/tb_lp_feeder.sv
// Directed, table-driven bench for lp_feeder; covers both LP_FEED_CHECK_EN builds.
module tb_lp_feeder;
  import lp_pkg::*;

  localparam int GAP = 2;

  typedef struct {
    lp_word_t words [7];
    bit       exp_drop;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic signed [5:0] s_a1, s_a2;
  logic signed [11:0] s_b;
  logic              lp_in_valid;
  logic signed [5:0] lp_in_a1, lp_in_a2;
  logic signed [11:0] lp_in_b;
  logic              lp_out_valid;
  logic              busy;
  logic [7:0]        frame_cnt;
  logic              drop_pulse;

  lp_feeder #(.GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_a1         (s_a1),
    .s_a2         (s_a2),
    .s_b          (s_b),
    .lp_in_valid  (lp_in_valid),
    .lp_in_a1     (lp_in_a1),
    .lp_in_a2     (lp_in_a2),
    .lp_in_b      (lp_in_b),
    .lp_out_valid (lp_out_valid),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .drop_pulse   (drop_pulse)
  );

  always #5 clk = ~clk;

  int       cyc = 0;
  int       n_pass = 0;
  int       n_tot = 0;
  int       n_timeout = 0;
  bit       abort = 1'b0;
  int       stalls = 0;
  int       last_acc = 0;
  int       pc = 0;
  int       run = 0;
  int       bad_len = 0;
  int       nz_err = 0;
  int       drop_cnt = 0;
  int       dc = 0;
  lp_word_t got_q [$];
  lp_word_t exp_q [$];
  int       start_q [$];
  vec_t     tab [6];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: collects burst words, burst start cycles and run lengths.
  always @(negedge clk) begin
    if (rst) begin
      run <= 0;
    end else begin
      if (lp_in_valid) begin
        got_q.push_back('{a1: lp_in_a1, a2: lp_in_a2, b: lp_in_b});
        if (run == 0) start_q.push_back(cyc);
        if (run >= 7) bad_len <= bad_len + 1;
        run <= run + 1;
      end else begin
        if (run != 0 && run != 7) bad_len <= bad_len + 1;
        run <= 0;
        if ({lp_in_a1, lp_in_a2, lp_in_b} != 24'd0) nz_err <= nz_err + 1;
      end
      if (drop_pulse) drop_cnt <= drop_cnt + 1;
    end
  end

  function automatic lp_word_t mk(input int a1, input int a2, input int b);
    return '{a1: 6'(a1), a2: 6'(a2), b: 12'(b)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
  endtask

  task automatic timeout(input string nm);
    n_tot++;
    n_timeout++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    if (n_timeout >= 3) abort = 1'b1;
  endtask

  task automatic send_word(input lp_word_t w);
    int n;
    n = 0;
    if (abort) return;
    s_valid = 1'b1;
    s_a1 = w.a1;
    s_a2 = w.a2;
    s_b  = w.b;
    while (s_ready !== 1'b1 && n < 400) begin
      stalls++;
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      timeout("s_ready_wait");
      return;
    end
    @(posedge clk);
    @(negedge clk);
    last_acc = cyc;
  endtask

  task automatic send_frame(input int f);
    for (int i = 0; i < 7; i++) begin
`ifdef LP_FEED_CHECK_EN
      if (!tab[f].exp_drop) exp_q.push_back(tab[f].words[i]);
`else
      exp_q.push_back(tab[f].words[i]);
`endif
      send_word(tab[f].words[i]);
    end
  endtask

  task automatic wait_level(input logic lvl, input int lim, input string nm);
    int n;
    n = 0;
    if (abort) return;
    while (lp_in_valid !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (lp_in_valid !== lvl) timeout(nm);
  endtask

  task automatic wait_cnt(input logic [7:0] val, input int lim, input string nm);
    int n;
    n = 0;
    if (abort) return;
    while (frame_cnt !== val && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (frame_cnt !== val) timeout(nm);
  endtask

  task automatic pulse_out(output int e);
    lp_out_valid = 1'b1;
    @(negedge clk);
    lp_out_valid = 1'b0;
    e = cyc;
  endtask

  task automatic compare_queues(input string nm);
    #1;
    check({nm, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check(nm, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0].words = '{mk(3,2,0), mk(1,0,5), mk(-1,0,0), mk(0,1,4), mk(0,-1,0), mk(1,1,6), mk(2,-1,7)};
    tab[0].exp_drop = 1'b0;
    tab[1].words = '{mk(-4,5,0), mk(0,-1,-3), mk(3,-2,100), mk(1,0,2047), mk(0,1,-2048), mk(-1,0,1), mk(-32,31,-1)};
    tab[1].exp_drop = 1'b0;
    tab[2].words = '{mk(31,-32,0), mk(-1,0,9), mk(1,0,-9), mk(0,1,12), mk(0,-1,-12), mk(5,5,55), mk(-7,6,-77)};
    tab[2].exp_drop = 1'b0;
    tab[3].words = '{mk(1,1,0), mk(0,1,1), mk(0,-1,2), mk(1,0,3), mk(-1,0,4), mk(2,2,5), mk(3,3,6)};
    tab[3].exp_drop = 1'b0;
    tab[4].words = '{mk(-2,-3,0), mk(1,0,-1), mk(2,0,-2), mk(0,-1,-3), mk(-1,0,-4), mk(0,1,-5), mk(0,0,-6)};
    tab[4].exp_drop = 1'b0;
    tab[5].words = '{mk(2,2,0), mk(1,0,3), mk(-1,0,3), mk(0,1,3), mk(1,1,3), mk(0,-2,3), mk(2,-1,3)};
    tab[5].exp_drop = 1'b1;

    rst = 1'b1;
    s_valid = 1'b0;
    s_a1 = '0;
    s_a2 = '0;
    s_b = '0;
    lp_out_valid = 1'b0;

    // Reset values
    @(negedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 1);
    check("rst_in_valid", 32'(lp_in_valid), 0);
    check("rst_data", 32'({lp_in_a1, lp_in_a2, lp_in_b}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_drop", 32'(drop_pulse), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single frame: latency, data order, busy held until result pulse
    start_q.delete();
    send_frame(0);
    s_valid = 1'b0;
    wait_level(1'b1, 20, "t1_start");
    wait_level(1'b0, 20, "t1_end");
    #1;
    check("t1_latency", 32'(start_q.size() > 0 ? start_q[0] : -1), 32'(last_acc + 1));
    check("t1_frame_cnt", 32'(frame_cnt), 1);
    check("t1_busy_wait", 32'(busy), 1);
    repeat (5) @(negedge clk);
    check("t1_busy_hold", 32'(busy), 1);
    pulse_out(pc);
    check("t1_busy_release", 32'(busy), 0);
    compare_queues("t1_word");

    // Back-to-back frames with s_valid held; second burst gap after the result pulse
    start_q.delete();
    stalls = 0;
    send_frame(1);
    send_frame(2);
    s_valid = 1'b0;
    check("t2_no_stall", 32'(stalls), 0);
    wait_cnt(8'd2, 40, "t2_first_done");
    pulse_out(pc);
    wait_level(1'b1, 40, "t2_second_start");
    wait_level(1'b0, 20, "t2_second_end");
    #1;
    check("t2_gap_start", 32'(start_q.size() > 1 ? start_q[1] : -1), 32'(pc + GAP + 1));
    check("t2_frame_cnt", 32'(frame_cnt), 3);
    compare_queues("t2_word");

    // Backpressure: FSM parked in WAIT, two frames fill both slots, third stalls
    stalls = 0;
    send_frame(3);
    send_frame(4);
    check("t3_no_stall_14", 32'(stalls), 0);
    check("t3_s_ready_full", 32'(s_ready), 0);
    fork
      begin
        send_frame(0);
        s_valid = 1'b0;
      end
      begin
        pulse_out(pc);
        for (int k = 0; k < 3; k++) begin
          wait_level(1'b1, 80, "t3_burst_start");
          wait_level(1'b0, 20, "t3_burst_end");
          pulse_out(pc);
        end
      end
    join
    check("t3_third_stalled", 32'(stalls != 0), 1);
    check("t3_frame_cnt", 32'(frame_cnt), 6);
    compare_queues("t3_word");

    // Asynchronous reset at burst cycle 3, then a fresh frame
    send_frame(1);
    s_valid = 1'b0;
    wait_level(1'b1, 30, "t4_start");
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t4_async_valid", 32'(lp_in_valid), 0);
    check("t4_async_data", 32'({lp_in_a1, lp_in_a2, lp_in_b}), 0);
    check("t4_async_cnt", 32'(frame_cnt), 0);
    check("t4_async_busy", 32'(busy), 0);
    check("t4_async_ready", 32'(s_ready), 1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    start_q.delete();
    @(negedge clk);
    send_frame(2);
    s_valid = 1'b0;
    wait_level(1'b1, 20, "t4_fresh_start");
    wait_level(1'b0, 20, "t4_fresh_end");
    #1;
    check("t4_latency", 32'(start_q.size() > 0 ? start_q[0] : -1), 32'(last_acc + 1));
    check("t4_frame_cnt", 32'(frame_cnt), 1);
    pulse_out(pc);
    compare_queues("t4_word");

    // Frame lacking the (0,-1) bound row
    dc = drop_cnt;
    send_frame(5);
    s_valid = 1'b0;
    repeat (20) @(negedge clk);
    #1;
`ifdef LP_FEED_CHECK_EN
    check("t5_drop_pulses", 32'(drop_cnt - dc), 1);
    check("t5_frame_cnt", 32'(frame_cnt), 1);
`else
    check("t5_drop_pulses", 32'(drop_cnt - dc), 0);
    check("t5_frame_cnt", 32'(frame_cnt), 2);
    pulse_out(pc);
`endif
    compare_queues("t5_word");

    // frame_cnt wrap after 256 frames from reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    #1;
    check("t6_cnt_reset", 32'(frame_cnt), 0);
    fork
      begin
        for (int f = 0; f < 256; f++) send_frame(f % 5);
        s_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 256; k++) begin
          wait_level(1'b1, 80, "t6_burst_start");
          wait_level(1'b0, 20, "t6_burst_end");
          if (k == 254) check("t6_cnt_255", 32'(frame_cnt), 255);
          pulse_out(pc);
        end
      end
    join
    check("t6_cnt_wrap", 32'(frame_cnt), 0);
    compare_queues("t6_word");

    check("burst_lengths", 32'(bad_len), 0);
    check("idle_data_zero", 32'(nz_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/lp_feeder.md
# lp_feeder

Upstream framing stage for the integer LP solver. Accepts problem words from a valid/ready source and buffers complete 7-word frames in two ping-pong slots. Each frame is 1 objective word followed by 6 constraint words. Frames are issued to the solver as one contiguous 7-cycle `in_valid` burst, and the next burst is held off until the solver's `out_valid` pulse returns.

## Interface
- `GAP_CYCLES`, default 1: idle cycles inserted after a sampled `lp_out_valid` before the next burst may start; legal range 1–15.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `s_valid`  in  1: upstream word valid.
- `s_ready`  out  1: a slot is accepting words.
- `s_a1`, `s_a2`  in  6 each, signed: coefficients; for word 0 these are c1 and c2.
- `s_b`  in  12, signed: bound; ignored for word 0.
- `lp_in_valid`  out  1: burst strobe to the solver.
- `lp_in_a1`, `lp_in_a2`  out  6 each, signed: burst data.
- `lp_in_b`  out  12, signed: burst data.
- `lp_out_valid`  in  1: solver result pulse.
- `busy`  out  1: high in SEND or WAIT.
- `frame_cnt`  out  8: bursts completed; wraps 255→0.
- `drop_pulse`  out  1: one-cycle pulse per dropped frame. Exists only with the macro; tied 0 without it.

## Operation
- Handshake: a word transfers when `s_valid && s_ready` at a rising edge. Word order inside a frame is fixed: index 0 is the objective, indices 1–6 are constraints.
- Slots: two slots, A and B, each holding 7 words, a write index 0..6, and a full flag.
  - Writes go to the slot pointed to by `wr_sel`.
  - When index 6 is accepted, that slot's full flag sets and `wr_sel` toggles.
  - `s_ready` equals NOT full of the `wr_sel` slot.
- Issue FSM:
  - IDLE → SEND when the `rd_sel` slot is full and the gap counter is 0.
  - SEND drives slot words 0..6 on 7 consecutive cycles with `lp_in_valid` = 1.
  - After word 6, SEND clears that slot's full flag, toggles `rd_sel`, increments `frame_cnt`, and moves to WAIT.
  - WAIT → IDLE on sampled `lp_out_valid` = 1. The gap counter loads with `GAP_CYCLES` and decrements to 0 in IDLE.
- When `lp_in_valid` = 0, data outputs are driven to 0.
- `lp_out_valid` outside WAIT is ignored.
- A slot freed in SEND may be rewritten starting the cycle after it is freed. Filling the other slot during SEND or WAIT is allowed.
- Both slots full: `s_ready` = 0 until SEND frees one.
- Simultaneous events: a slot completing on the same edge SEND frees the other slot is legal. Both flags update independently.
- No arithmetic on data; words pass through bit-exact.

## Timing
- Reset values:
  - `s_ready` = 1, `lp_in_valid` = 0.
  - `lp_in_a1`, `lp_in_a2`, `lp_in_b` = 0.
  - `busy` = 0, `frame_cnt` = 0, `drop_pulse` = 0.
  - FSM = IDLE, both slots empty, `wr_sel` = `rd_sel` = A, gap counter = 0.
- Latency: if the FSM is IDLE, the gap is 0, and the frame's last word is accepted at edge t, then `lp_in_valid` rises after edge t+1. The first burst word is visible in the cycle following that edge.
- A burst is exactly 7 contiguous cycles and is never interrupted except by `rst`.
- Next-burst start: no earlier than GAP_CYCLES+1 edges after the edge that samples `lp_out_valid`.
- `rst` mid-burst or mid-fill: outputs go to their reset values immediately (asynchronous), and all buffered words are discarded.

## Configuration
- `LP_FEED_CHECK_EN` defined: at frame completion, words 1–6 must include each of the four bound rows (a1,a2) = (1,0), (−1,0), (0,1), (0,−1).
  - A frame missing any bound row is dropped: its slot is freed without a burst, `frame_cnt` is unchanged, and `drop_pulse` = 1 for one cycle.
- Not defined: no check is performed and every complete frame is issued.

## Structure
- Package `lp_pkg` holds:
  - constants `LP_A_W` = 6, `LP_B_W` = 12, `LP_FRAME_WORDS` = 7;
  - `lp_word_t`, a packed struct {a1, a2, b};
  - `lp_feed_state_e` with values IDLE, SEND, WAIT.
- One sub-module, `lp_feed_slot`: a 7-entry `lp_word_t` register file with write index, full flag, clear input, and indexed read port. Instantiated twice.

## Test plan
- Single frame:
  - Input: obj (3,2), then (1,0,5), (−1,0,0), (0,1,4), (0,−1,0), (1,1,6), (2,−1,7).
  - Required: 7-cycle burst with those words in order; `frame_cnt` = 1; `busy` stays high until `lp_out_valid`.
- Back-to-back frames: 2 frames sent with `s_valid` held at 1.
  - Required: second burst starts exactly GAP_CYCLES+1 edges after the `lp_out_valid` edge.
  - Required: `s_ready` = 0 only while a third frame is pending.
- Backpressure: 3 frames queued while `lp_out_valid` is withheld.
  - Required: `s_ready` = 0 after 14 words are buffered.
  - Required: a pulse on `lp_out_valid` resumes output, and all 21 words emerge in order.
- Reset at burst cycle 3: `lp_in_valid` drops to 0 asynchronously, `frame_cnt` = 0, and a fresh frame afterwards is issued normally.
- `LP_FEED_CHECK_EN` on, frame lacking (0,−1): `drop_pulse` = 1 for one cycle, no burst, `frame_cnt` unchanged. The same frame passes through with the macro off.
- `frame_cnt` wrap: 256 frames → `frame_cnt` = 0.
